// File: rtl/scan_pkg.sv
// Shared types and sizes for the display digit scanner.
package scan_pkg;

    localparam int N_DIGITS = 8;
    localparam int SEL_W    = 3;

    typedef enum logic [1:0] {
        IDLE,
        BLNK,
        SHOW
    } state_t;

endpackage

// File: rtl/next_digit_finder.sv
// Combinational search for the next enabled digit above cur, wrapping.
module next_digit_finder
    import scan_pkg::*;
(
    input  logic [N_DIGITS-1:0] mask,
    input  logic [SEL_W-1:0]    cur,
    output logic [SEL_W-1:0]    nxt,
    output logic                wrap,
    output logic                none
);

    logic [SEL_W:0]          sh;
    logic [2*N_DIGITS-1:0]   dbl;
    logic [N_DIGITS-1:0]     rot;
    logic [SEL_W-1:0]        off;

    always_comb begin
        // rot[0] lines up with digit cur+1, so the lowest set bit is the answer
        sh   = {1'b0, cur} + {{SEL_W{1'b0}}, 1'b1};
        dbl  = {mask, mask} >> sh;
        rot  = dbl[N_DIGITS-1:0];
        off  = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            if (rot[i]) off = SEL_W'(i);
        end
        nxt  = cur + off + SEL_W'(1);
        none = ~|mask;
        wrap = !none && (nxt <= cur);
    end

endmodule

// File: rtl/scan_sequencer.sv
// Round-robin digit-select sequencer with dwell and inter-digit blanking.
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int DIV   = 4,
    parameter int BLANK = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [N_DIGITS-1:0] digit_mask,
    output logic [SEL_W-1:0]    sel,
    output logic                blank,
    output logic                frame_done,
    output logic                active
);

    localparam int LEN_MAX = (DIV > BLANK) ? DIV : BLANK;
    localparam int CW      = $clog2(LEN_MAX + 1);
    localparam logic [CW-1:0] DIV_LD   = CW'(DIV);
    localparam logic [CW-1:0] BLANK_LD = CW'(BLANK);
    localparam logic [CW-1:0] ONE      = CW'(1);

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [SEL_W-1:0]  sel_n;
    logic              blank_n, fd_n, active_n;
    logic [SEL_W-1:0]  cur, nxt;
    logic              wrap, none;

    // From IDLE, searching above the top digit yields the lowest set bit
    assign cur = (state == SHOW) ? sel : SEL_W'(N_DIGITS - 1);

    next_digit_finder u_find (
        .mask (digit_mask),
        .cur  (cur),
        .nxt  (nxt),
        .wrap (wrap),
        .none (none)
    );

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        sel_n    = sel;
        blank_n  = blank;
        fd_n     = 1'b0;
        active_n = active;
        unique case (state)
            IDLE: begin
                if (!none) begin
                    state_n  = BLNK;
                    cnt_n    = BLANK_LD;
                    sel_n    = nxt;
                    blank_n  = 1'b1;
                    active_n = 1'b1;
                end
            end
            BLNK: begin
                if (cnt == ONE) begin
                    state_n = SHOW;
                    cnt_n   = DIV_LD;
                    blank_n = 1'b0;
                end else begin
                    cnt_n = cnt - ONE;
                end
            end
            SHOW: begin
                if (cnt != ONE) begin
                    cnt_n = cnt - ONE;
                end else if (none) begin
                    state_n  = IDLE;
                    cnt_n    = '0;
                    sel_n    = '0;
                    blank_n  = 1'b1;
                    active_n = 1'b0;
                end else begin
                    state_n = BLNK;
                    cnt_n   = BLANK_LD;
                    sel_n   = nxt;
                    fd_n    = wrap;
                    blank_n = 1'b1;
                end
            end
            default: begin
                state_n  = IDLE;
                cnt_n    = '0;
                sel_n    = '0;
                blank_n  = 1'b1;
                active_n = 1'b0;
            end
        endcase
        if (!en) begin
            state_n  = IDLE;
            cnt_n    = '0;
            sel_n    = '0;
            blank_n  = 1'b1;
            fd_n     = 1'b0;
            active_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            sel        <= '0;
            blank      <= 1'b1;
            frame_done <= 1'b0;
            active     <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            sel        <= sel_n;
            blank      <= blank_n;
            frame_done <= fd_n;
            active     <= active_n;
        end
    end

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer against a digit-period schedule model.
module tb_scan_sequencer;

    localparam int DIV   = 4;
    localparam int BLANK = 1;
    localparam int PER   = DIV + BLANK;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b1;
    logic [7:0] digit_mask = 8'hFF;
    logic [2:0] sel;
    logic       blank, frame_done, active;

    int n_cmp = 0;
    int n_bad = 0;
    bit done  = 1'b0;

    scan_sequencer #(.DIV(DIV), .BLANK(BLANK)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .digit_mask (digit_mask),
        .sel        (sel),
        .blank      (blank),
        .frame_done (frame_done),
        .active     (active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [7:0] m);
        for (int i = 0; i < 8; i++) if (m[i]) return i;
        return 0;
    endfunction

    function automatic int next_above(input logic [7:0] m, input int s);
        for (int i = s + 1; i < 8; i++) if (m[i]) return i;
        return lowest(m);
    endfunction

    // Model: running flag, current digit, position inside the digit period
    bit m_run = 1'b0;
    int m_sel = 0;
    int m_t   = 0;
    bit m_fd  = 1'b0;

    always @(posedge clk) begin
        int ns;
        if (rst || !en) begin
            m_run = 1'b0; m_sel = 0; m_t = 0; m_fd = 1'b0;
        end else if (!m_run) begin
            m_fd = 1'b0;
            if (digit_mask != 8'h00) begin
                m_run = 1'b1; m_sel = lowest(digit_mask); m_t = 0;
            end
        end else begin
            m_fd = 1'b0;
            if (m_t == PER - 1) begin
                if (digit_mask == 8'h00) begin
                    m_run = 1'b0; m_sel = 0; m_t = 0;
                end else begin
                    ns = next_above(digit_mask, m_sel);
                    m_fd = (ns <= m_sel);
                    m_sel = ns; m_t = 0;
                end
            end else begin
                m_t++;
            end
        end
    end

    always @(negedge clk) begin
        if (!done) begin
            chk("model_sel", int'(sel), m_sel);
            chk("model_blank", int'(blank), int'(!m_run || m_t < BLANK));
            chk("model_frame_done", int'(frame_done), int'(m_fd));
            chk("model_active", int'(active), int'(m_run));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    int fdi[$];
    int shows[$];
    int nshow;

    task automatic run_rec(input int n);
        bit pb;
        fdi.delete(); shows.delete(); nshow = 0; pb = 1'b1;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (frame_done) fdi.push_back(i);
            if (pb && !blank) shows.push_back(int'(sel));
            if (!blank) nshow++;
            pb = blank;
        end
    endtask

    task automatic wait_show(input int s);
        int k;
        k = 0;
        while (!(int'(sel) == s && !blank) && k < 200) begin
            tick();
            k++;
        end
        chk("wait_show_timeout", int'(k < 200), 1);
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_sel"}, int'(sel), 0);
        chk({name, "_blank"}, int'(blank), 1);
        chk({name, "_fd"}, int'(frame_done), 0);
        chk({name, "_active"}, int'(active), 0);
    endtask

    task automatic restart(input logic [7:0] m);
        en = 1'b0;
        tick();
        digit_mask = m;
        en = 1'b1;
    endtask

    initial begin
        int exp_full[9];
        int exp_sparse[4];
        exp_full   = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
        exp_sparse = '{2, 5, 7, 2};

        for (int i = 0; i < 3; i++) begin
            tick();
            chk_idle("reset");
        end
        rst = 1'b0;

        run_rec(85);
        for (int k = 0; k < 9; k++)
            chk("full_seq", (shows.size() > k) ? shows[k] : -1, exp_full[k]);
        chk("full_fd_count", fdi.size(), 2);
        chk("full_fd_first", (fdi.size() > 0) ? fdi[0] : -1, 41);
        chk("full_fd_period", (fdi.size() > 1) ? fdi[1] - fdi[0] : -1, 40);
        chk("full_show_cycles", nshow, 68);

        restart(8'b1010_0100);
        run_rec(45);
        for (int k = 0; k < 4; k++)
            chk("sparse_seq", (shows.size() > k) ? shows[k] : -1, exp_sparse[k]);
        chk("sparse_fd_count", fdi.size(), 2);
        chk("sparse_fd_first", (fdi.size() > 0) ? fdi[0] : -1, 16);
        chk("sparse_fd_period", (fdi.size() > 1) ? fdi[1] - fdi[0] : -1, 15);

        restart(8'h08);
        run_rec(25);
        chk("single_digits", shows.size(), 5);
        foreach (shows[k]) chk("single_sel", shows[k], 3);
        chk("single_fd_count", fdi.size(), 4);
        chk("single_fd_first", (fdi.size() > 0) ? fdi[0] : -1, 6);
        chk("single_show_cycles", nshow, 20);

        restart(8'hFF);
        wait_show(4);
        tick();
        digit_mask = 8'h00;
        tick();
        chk("clr_blank3", int'(blank), 0);
        chk("clr_sel3", int'(sel), 4);
        tick();
        chk("clr_blank4", int'(blank), 0);
        tick();
        chk_idle("clr_idle");
        tick();
        chk_idle("clr_idle_hold");

        digit_mask = 8'hFF;
        wait_show(5);
        rst = 1'b1;
        tick();
        chk_idle("rst_mid");
        rst = 1'b0;
        digit_mask = 8'h0C;
        tick();
        chk("rst_restart_sel", int'(sel), 2);
        chk("rst_restart_blank", int'(blank), 1);
        chk("rst_restart_active", int'(active), 1);
        chk("rst_restart_fd", int'(frame_done), 0);
        tick();
        chk("rst_restart_show", int'(blank), 0);

        digit_mask = 8'hFF;
        wait_show(5);
        en = 1'b0;
        tick();
        chk_idle("dis_mid");
        en = 1'b1;
        digit_mask = 8'h0C;
        tick();
        chk("dis_restart_sel", int'(sel), 2);
        chk("dis_restart_blank", int'(blank), 1);
        chk("dis_restart_active", int'(active), 1);
        chk("dis_restart_fd", int'(frame_done), 0);
        tick();

        done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
